// File: rtl/dmem_arbiter.sv
// Two-requester arbiter (CPU MEM stage vs. peripheral master) for one single-port synchronous RAM.
// Optional macro DMEM_ARB_CPU_PRIO_EN: CPU fixed priority with bounded dev starvation instead of round-robin.
module dmem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_stall,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dev_req,
  input  logic          dev_we,
  input  logic [AW-1:0] dev_addr,
  input  logic [DW-1:0] dev_wdata,
  output logic          dev_gnt,
  output logic          dev_rvalid,
  output logic [DW-1:0] dev_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-3:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  logic          w_dev_wins;
  logic          w_cpu_gnt;
  logic          w_dev_gnt;
  logic          w_unused;
  logic          r_rpend;
  logic          r_rsel;
  logic [DW-1:0] r_cpu_rdata;
  logic [DW-1:0] r_dev_rdata;

  // Byte-offset bits never reach the word-addressed RAM.
  assign w_unused = &{1'b0, cpu_addr[1:0], dev_addr[1:0]};

`ifdef DMEM_ARB_CPU_PRIO_EN
  localparam int CW = $clog2(MAX_WAIT + 1);
  logic [CW-1:0] r_wait;

  // Dev only beats the CPU once it has been denied MAX_WAIT cycles in a row.
  assign w_dev_wins = (r_wait >= CW'(MAX_WAIT));

  always_ff @(posedge clk) begin
    if (rst)
      r_wait <= '0;
    else if (dev_req && !w_dev_gnt)
      r_wait <= (r_wait >= CW'(MAX_WAIT)) ? r_wait : r_wait + CW'(1);
    else
      r_wait <= '0;
  end
`else
  localparam int UNUSED_MAX_WAIT = MAX_WAIT;
  logic r_last_grant;

  // Round-robin: on conflict the requester not recorded as last winner goes next.
  assign w_dev_wins = ~r_last_grant;

  always_ff @(posedge clk) begin
    if (rst)
      r_last_grant <= 1'b1;
    else if (w_cpu_gnt || w_dev_gnt)
      r_last_grant <= w_dev_gnt;
  end
`endif

  assign w_cpu_gnt = ~rst & cpu_req & (~dev_req | ~w_dev_wins);
  assign w_dev_gnt = ~rst & dev_req & (~cpu_req |  w_dev_wins);

  assign cpu_stall = ~rst & cpu_req & ~w_cpu_gnt;
  assign dev_gnt   = w_dev_gnt;

  assign mem_en    = w_cpu_gnt | w_dev_gnt;
  assign mem_we    = w_dev_gnt ? dev_we : (w_cpu_gnt & cpu_we);
  assign mem_addr  = w_dev_gnt ? dev_addr[AW-1:2] : cpu_addr[AW-1:2];
  assign mem_wdata = w_dev_gnt ? dev_wdata : cpu_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rpend <= 1'b0;
      r_rsel  <= 1'b0;
    end else begin
      r_rpend <= mem_en & ~mem_we;
      r_rsel  <= w_dev_gnt;
    end
  end

  // Gated with rst so a read granted just before reset never returns.
  assign cpu_rvalid = ~rst & r_rpend & ~r_rsel;
  assign dev_rvalid = ~rst & r_rpend &  r_rsel;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cpu_rdata <= '0;
      r_dev_rdata <= '0;
    end else begin
      if (cpu_rvalid) r_cpu_rdata <= mem_rdata;
      if (dev_rvalid) r_dev_rdata <= mem_rdata;
    end
  end

  assign cpu_rdata = rst ? '0 : (cpu_rvalid ? mem_rdata : r_cpu_rdata);
  assign dev_rdata = rst ? '0 : (dev_rvalid ? mem_rdata : r_dev_rdata);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: RAM stub, transaction-level reference model checked every cycle, literal spot checks.
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MAX_WAIT = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_req = 0, cpu_we = 0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          dev_req = 0, dev_we = 0;
  logic [AW-1:0] dev_addr = '0;
  logic [DW-1:0] dev_wdata = '0;
  logic          cpu_stall, cpu_rvalid, dev_gnt, dev_rvalid, mem_en, mem_we;
  logic [DW-1:0] cpu_rdata, dev_rdata, mem_wdata, mem_rdata;
  logic [AW-3:0] mem_addr;

  int n_chk = 0;
  int n_err = 0;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dev_req(dev_req), .dev_we(dev_we), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
    .dev_gnt(dev_gnt), .dev_rvalid(dev_rvalid), .dev_rdata(dev_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Read-first synchronous RAM stub.
  logic [DW-1:0] ram [0:255];
  always @(posedge clk) begin
    if (mem_en && mem_we) ram[mem_addr[7:0]] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= ram[mem_addr[7:0]];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: words stored by address, one outstanding read return, last winner.
  logic [DW-1:0] ref_mem [0:255];
  logic          m_last = 1'b1;
  int            m_wait = 0;
  logic          m_pend = 1'b0, m_psel = 1'b0;
  logic [DW-1:0] m_pdata = '0, m_chold = '0, m_dhold = '0;
  logic          e_cg, e_dg, e_cv, e_dv;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_stall", cpu_stall, 0);
      check("rst_gnt", dev_gnt, 0);
      check("rst_en", mem_en, 0);
      check("rst_we", mem_we, 0);
      check("rst_crv", cpu_rvalid, 0);
      check("rst_drv", dev_rvalid, 0);
      check("rst_crd", cpu_rdata, 0);
      check("rst_drd", dev_rdata, 0);
      m_last = 1'b1; m_wait = 0; m_pend = 1'b0;
      m_chold = '0; m_dhold = '0;
    end else begin
      if (cpu_req && dev_req) begin
`ifdef DMEM_ARB_CPU_PRIO_EN
        e_dg = (m_wait >= MAX_WAIT);
`else
        e_dg = (m_last == 1'b0);
`endif
        e_cg = !e_dg;
      end else begin
        e_cg = cpu_req;
        e_dg = dev_req;
      end
      check("cpu_stall", cpu_stall, cpu_req && !e_cg);
      check("dev_gnt", dev_gnt, e_dg);
      check("mem_en", mem_en, e_cg || e_dg);
      check("mem_we", mem_we, (e_cg && cpu_we) || (e_dg && dev_we));
      if (e_cg || e_dg)
        check("mem_addr", mem_addr, e_dg ? dev_addr[AW-1:2] : cpu_addr[AW-1:2]);
      if (mem_we && (e_cg || e_dg))
        check("mem_wdata", mem_wdata, e_dg ? dev_wdata : cpu_wdata);

      e_cv = m_pend && !m_psel;
      e_dv = m_pend && m_psel;
      check("cpu_rvalid", cpu_rvalid, e_cv);
      check("dev_rvalid", dev_rvalid, e_dv);
      check("cpu_rdata", cpu_rdata, e_cv ? m_pdata : m_chold);
      check("dev_rdata", dev_rdata, e_dv ? m_pdata : m_dhold);
      if (e_cv) m_chold = m_pdata;
      if (e_dv) m_dhold = m_pdata;

      m_pend = 1'b0;
      if (e_cg) begin
        if (cpu_we) ref_mem[cpu_addr[9:2]] = cpu_wdata;
        else begin m_pend = 1'b1; m_psel = 1'b0; m_pdata = ref_mem[cpu_addr[9:2]]; end
      end
      if (e_dg) begin
        if (dev_we) ref_mem[dev_addr[9:2]] = dev_wdata;
        else begin m_pend = 1'b1; m_psel = 1'b1; m_pdata = ref_mem[dev_addr[9:2]]; end
      end
      if (e_cg || e_dg) m_last = e_dg;
      m_wait = (dev_req && !e_dg) ? m_wait + 1 : 0;
    end
  end

  task automatic cyc;
    @(posedge clk); #1;
  endtask

  task automatic cpu(input logic r, input logic we, input logic [31:0] a, input logic [31:0] d);
    cpu_req = r; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic dev(input logic r, input logic we, input logic [31:0] a, input logic [31:0] d);
    dev_req = r; dev_we = we; dev_addr = a; dev_wdata = d;
  endtask

  int cg, dg, crv, drv;

  initial begin
    for (int i = 0; i < 256; i++) begin ram[i] = '0; ref_mem[i] = '0; end
    cyc; cyc;
    rst = 1'b0;

    // CPU only: write then read back.
    cpu(1, 1, 32'h10, 32'hDEADBEEF);
    @(negedge clk);
    check("t1_wr_stall", cpu_stall, 0);
    check("t1_wr_addr", mem_addr, 30'h4);
    cyc; cpu(1, 0, 32'h10, 0);
    cyc; cpu(0, 0, 0, 0);
    @(negedge clk);
    check("t1_rvalid", cpu_rvalid, 1);
    check("t1_rdata", cpu_rdata, 32'hDEADBEEF);
    check("t1_dev_rvalid", dev_rvalid, 0);

    // Preload words 0x0 and 0x4, then reset before the conflict.
    cyc; cpu(1, 1, 32'h0, 32'h11110000);
    cyc; cpu(1, 1, 32'h4, 32'h22220004);
    cyc; cpu(0, 0, 0, 0); rst = 1'b1;
    cyc; rst = 1'b0;

    // Simultaneous reads, first conflict after reset goes to the CPU.
    cpu(1, 0, 32'h0, 0); dev(1, 0, 32'h4, 0);
    @(negedge clk);
    check("t2_c0_dev_gnt", dev_gnt, 0);
    check("t2_c0_stall", cpu_stall, 0);
    cyc; cpu(0, 0, 0, 0);
    @(negedge clk);
    check("t2_c1_dev_gnt", dev_gnt, 1);
    check("t2_c1_crv", cpu_rvalid, 1);
    check("t2_c1_crd", cpu_rdata, 32'h11110000);
    cyc; dev(0, 0, 0, 0);
    @(negedge clk);
    check("t2_c2_drv", dev_rvalid, 1);
    check("t2_c2_drd", dev_rdata, 32'h22220004);

    // Both requesters read continuously for 8 cycles.
    cyc; cpu(1, 0, 32'h0, 0); dev(1, 0, 32'h4, 0);
    cg = 0; dg = 0; crv = 0; drv = 0;
    for (int k = 0; k < 9; k++) begin
      if (k == 8) begin cpu(0, 0, 0, 0); dev(0, 0, 0, 0); end
      @(negedge clk);
      cg += int'(cpu_req && !cpu_stall); dg += int'(dev_gnt);
      crv += int'(cpu_rvalid); drv += int'(dev_rvalid);
      cyc;
    end
`ifdef DMEM_ARB_CPU_PRIO_EN
    check("t3_cpu_grants", cg, 7);
    check("t3_dev_grants", dg, 1);
    check("t3_cpu_rvalids", crv, 7);
    check("t3_dev_rvalids", drv, 1);
`else
    check("t3_cpu_grants", cg, 4);
    check("t3_dev_grants", dg, 4);
    check("t3_cpu_rvalids", crv, 4);
    check("t3_dev_rvalids", drv, 4);
`endif

    // Reset between a granted read and its return.
    cpu(1, 0, 32'h4, 0);
    cyc; cpu(0, 0, 0, 0); rst = 1'b1;
    @(negedge clk);
    check("t4_rst_crv", cpu_rvalid, 0);
    cyc; rst = 1'b0;
    @(negedge clk);
    check("t4_post_crv", cpu_rvalid, 0);
    cyc; cpu(1, 0, 32'h0, 0); dev(1, 0, 32'h4, 0);
    @(negedge clk);
    check("t4_conf_dev_gnt", dev_gnt, 0);
    check("t4_conf_stall", cpu_stall, 0);
    cyc; cpu(0, 0, 0, 0);
    @(negedge clk);
    check("t4_dev_gnt", dev_gnt, 1);
    cyc; dev(0, 0, 0, 0);

    // Write/write conflict at 0x20: CPU first, dev second.
    cyc; cpu(1, 1, 32'h20, 32'h1111); dev(1, 1, 32'h20, 32'h2222);
    @(negedge clk);
    check("t5_stall", cpu_stall, 0);
    cyc; cpu(0, 0, 0, 0);
    cyc; dev(0, 0, 0, 0); cpu(1, 0, 32'h20, 0);
    cyc; cpu(0, 0, 0, 0);
    @(negedge clk);
    check("t5_crv", cpu_rvalid, 1);
    check("t5_crd", cpu_rdata, 32'h2222);

    // Read-then-write same address returns old data.
    cyc; cpu(1, 1, 32'h30, 32'h0BADF00D);
    cyc; cpu(0, 0, 0, 0); dev(1, 0, 32'h30, 0);
    cyc; dev(1, 1, 32'h30, 32'h12345678);
    @(negedge clk);
    check("t6_drv", dev_rvalid, 1);
    check("t6_drd", dev_rdata, 32'h0BADF00D);
    cyc; dev(0, 0, 0, 0); cpu(1, 0, 32'h30, 0);
    cyc; cpu(0, 0, 0, 0);
    @(negedge clk);
    check("t6_crd", cpu_rdata, 32'h12345678);
    check("t6_drd_hold", dev_rdata, 32'h0BADF00D);
    cyc; cyc;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
